// File: rtl/sar_code_fifo_if.sv
// ---------------------------------------------------------------------------
// sar_code_fifo_if
//   Bundles the code-capture and readout signals of sar_code_fifo.
//
//   din        : conversion code from the SAR (din[9] = D9 ... din[0] = D0)
//   conv_done  : one-cycle strobe, din valid in this cycle
//   dout       : FIFO head (averaged code)
//   dout_valid : FIFO head is valid
//   dout_ready : consumer accepts dout when dout_valid & dout_ready
//   level      : FIFO occupancy, 0..DEPTH
//   ovf        : sticky overflow flag
//   clr_ovf    : clears ovf
//
//   master : the SAR/readout side that drives codes and drains results
//   slave  : the sar_code_fifo block itself
// ---------------------------------------------------------------------------
interface sar_code_fifo_if #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8
);
    logic [DATA_W-1:0]        din;
    logic                     conv_done;
    logic [DATA_W-1:0]        dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [$clog2(DEPTH):0]   level;
    logic                     ovf;
    logic                     clr_ovf;

    modport master (
        output din, conv_done, dout_ready, clr_ovf,
        input  dout, dout_valid, level, ovf
    );

    modport slave (
        input  din, conv_done, dout_ready, clr_ovf,
        output dout, dout_valid, level, ovf
    );
endinterface

// File: rtl/sar_code_fifo.sv
// ---------------------------------------------------------------------------
// sar_code_fifo
//   Captures 10-bit SAR conversion codes on conv_done, averages
//   2^AVG_LOG2 consecutive codes with round-half-up, and queues the
//   results in a show-ahead FIFO drained through a valid/ready handshake.
//
//   Ports:
//     CLKS : sample clock, all logic on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : sar_code_fifo_if.slave (din, conv_done, dout, dout_valid,
//            dout_ready, level, ovf, clr_ovf)
//
//   Parameters:
//     DATA_W   : code width
//     AVG_LOG2 : log2 of samples per result (0..4, 0 = pass-through)
//     DEPTH    : FIFO entries, power of two, >= 2
// ---------------------------------------------------------------------------
module sar_code_fifo #(
    parameter int DATA_W   = 10,
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 8
) (
    input  logic            CLKS,
    input  logic            rst,
    sar_code_fifo_if.slave  bus
);

    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int RND_SH = (AVG_LOG2 > 0) ? AVG_LOG2 - 1 : 0;

    // With AVG_LOG2 = 0 the counter is a constant 0 that always equals
    // CNT_LAST, so every strobe finishes a result without special casing.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ACC_W:0]   RND      = (AVG_LOG2 > 0) ?
                                            ((ACC_W + 1)'(1) << RND_SH) :
                                            (ACC_W + 1)'(0);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_PUSH = 1'b1
    } state_t;

    // Averaging front end
    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [ACC_W:0]      sum_rnd;
    logic                last_sample;

    // FIFO
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [LVL_W-1:0]    head_avail;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                ovf_q, ovf_d;
    logic                wr_req, wr_en, pop, full, ovf_set;

    // Averaging FSM, next state. acc and cnt are already cleared whenever
    // we sit in PUSH, so a strobe arriving in PUSH simply restarts the
    // accumulation (acc = din, cnt = 1) through the same path as in ACC;
    // with AVG_LOG2 = 0 that strobe produces the next result and we stay
    // in PUSH.
    always_comb begin
        state_d     = ST_ACC;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        last_sample = (cnt_q == CNT_LAST);
        sum_rnd     = {1'b0, acc_q} + (ACC_W + 1)'(bus.din) + RND;

        unique case (state_q)
            ST_ACC, ST_PUSH: begin
                if (bus.conv_done) begin
                    if (last_sample) begin
                        result_d = DATA_W'(sum_rnd >> AVG_LOG2);
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_PUSH;
                    end else begin
                        acc_d    = acc_q + ACC_W'(bus.din);
                        cnt_d    = cnt_q + CNT_W'(1);
                        state_d  = ST_ACC;
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // FIFO control. The registered head only looks at entries that were
    // already stored before this edge, so a write becomes visible on dout
    // one edge later; a pop exposes the next stored entry with no bubble.
    always_comb begin
        wr_req     = (state_q == ST_PUSH);
        pop        = dout_valid_q & bus.dout_ready;
        full       = (level_q == LVL_W'(DEPTH));
        wr_en      = wr_req & (~full | pop);
        ovf_set    = wr_req & full & ~pop;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = result_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        head_avail   = level_q - LVL_W'(pop);
        dout_valid_d = (head_avail != '0);
        dout_d       = dout_valid_d ? mem_q[rd_ptr_d] : dout_q;

        // Set beats clear when both happen in the same cycle.
        ovf_d        = ovf_set | (ovf_q & ~bus.clr_ovf);
    end

    // State and control registers with synchronous reset; reset drops any
    // partial sum and empties the FIFO.
    always_ff @(posedge CLKS) begin
        if (rst) begin
            state_q      <= ST_ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage needs no reset: level and pointers decide what is valid.
    always_ff @(posedge CLKS) begin
        mem_q <= mem_d;
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.level      = level_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: doc/sar_code_fifo.md
Name: sar_code_fifo

Overview:
- Downstream stage of the SAR conversion logic, clocked by the same sample clock CLKS.
- Captures each 10-bit conversion result (D9..D0 packed as din[9:0], D9 = MSB) on the conversion-done strobe.
- Optionally averages 2^AVG_LOG2 consecutive codes with rounding.
- Buffers the results in a show-ahead FIFO that the readout logic drains through a valid/ready handshake.

Parameters:
- DATA_W, 10, code width (matches SAR output D9..D0)
- AVG_LOG2, 2, log2 of samples averaged per result; legal 0..4; 0 = pass-through
- DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
- CLKS  input  1  sample clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  DATA_W  conversion code from SAR; din[9]=D9 ... din[0]=D0
- conv_done  input  1  one-cycle strobe; din is valid in this cycle
- dout  output  DATA_W  FIFO head (averaged code)
- dout_valid  output  1  FIFO non-empty
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- ovf  output  1  sticky overflow flag
- clr_ovf  input  1  clears ovf

Behaviour:
- Reset: one clock, synchronous and active-high. While rst=1 at a CLKS edge:
  - dout=0, dout_valid=0, level=0, ovf=0;
  - accumulator=0, sample count=0, state=ACC.
  - rst asserted mid-accumulation discards the partial sum and all FIFO contents.
- Accumulator: width DATA_W+AVG_LOG2, so there is no overflow. The sample counter is AVG_LOG2 bits wide.
- State ACC:
  - On conv_done: acc += din and cnt += 1.
  - When conv_done arrives with cnt == 2^AVG_LOG2-1, register result = (acc + din + R) >> AVG_LOG2, where R = 2^(AVG_LOG2-1), or 0 when AVG_LOG2=0.
  - Then clear acc and cnt and go to PUSH.
  - The result always fits DATA_W (max 1023), so no saturation is needed.
- State PUSH (exactly one cycle):
  - Write result into the FIFO, then return to ACC.
  - A conv_done arriving in PUSH is not lost: acc=din, cnt=1 (or, if AVG_LOG2=0, it produces the next result and stays in PUSH).
- Latency: conv_done of the final sample at edge t → FIFO write at edge t+1 → dout_valid=1 after edge t+2 if the FIFO was empty.
- FIFO:
  - Circular buffer with DEPTH entries, write/read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a separate level counter.
  - dout/dout_valid are registered and show-ahead: dout always equals the oldest entry when dout_valid=1.
  - Pop occurs on dout_valid & dout_ready; the next entry appears on dout the following cycle with no bubble.
  - dout_ready while empty has no effect.
- Full (level==DEPTH) with a write and no pop: the result is dropped, ovf←1, and contents and order are unchanged.
- Full with simultaneous write and pop: both succeed, level stays DEPTH, ovf unchanged.
- Empty with a write: level→1, and dout_valid rises on the next edge (the write is not visible in the same cycle).
- ovf is sticky until clr_ovf=1. If overflow and clr_ovf occur in the same cycle, set wins.
- When dout_valid=0, dout holds its last value. Checkers compare dout only when dout_valid=1.
- din is ignored when conv_done=0.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream → dout=0, dout_valid=0, level=0, ovf=0; the following 4 codes of 8 give dout=8.
- AVG_LOG2=2, codes 100,101,102,103 on four conv_done strobes → dout_valid rises 2 edges after the 4th strobe, dout=102 ((406+2)>>2), level=1.
- Rounding: codes 1,1,1,2 → dout=1; codes 1,1,2,2 → dout=2; 4×1023 → dout=1023; back-to-back conv_done every cycle gives no lost samples.
- Fill/overflow with DEPTH=8 and dout_ready=0: 9 results → level=8, ovf=1, then drain yields the first 8 results in order. Pulse clr_ovf → ovf=0.
- Full with dout_ready=1 and a result written in the same cycle → level stays 8, ovf stays 0, and the popped value is the oldest.
- AVG_LOG2=0 pass-through: codes 0x3FF,0x000,0x155 on consecutive cycles with dout_ready=1 → dout sequence 0x3FF,0x000,0x155, each valid for one cycle, latency 2.
